// File: rtl/tb_package.sv
// Shared types and constants for the command script runner.
package tb_package;

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StWaitSent,
      StWaitResp,
      StCheck,
      StDone
   } state_e;

   localparam logic [7:0] COMM_COMPLETE = 8'hA5;

endpackage

// File: rtl/cmd_script_runner_if.sv
// Script load, run control, RemoteComm handshake and result signals of the runner.
interface cmd_script_runner_if #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned CMD_W = 16
);
   localparam int unsigned AW = $clog2(DEPTH);

   logic             load_we;
   logic [AW-1:0]    load_addr;
   logic [CMD_W-1:0] load_cmd;
   logic [7:0]       load_exp;
   logic [AW:0]      num_cmds;
   logic             start;
   logic [CMD_W-1:0] cmd;
   logic             send_cmd;
   logic             cmd_sent;
   logic             resp_rdy;
   logic [7:0]       resp;
   logic             clr_rx_rdy;
   logic             busy;
   logic             done;
   logic [AW:0]      pass_cnt;
   logic [AW:0]      fail_cnt;
   logic [AW-1:0]    first_fail;

   modport master (
      output load_we, load_addr, load_cmd, load_exp, num_cmds, start, cmd_sent, resp_rdy, resp,
      input  cmd, send_cmd, clr_rx_rdy, busy, done, pass_cnt, fail_cnt, first_fail
   );

   modport slave (
      input  load_we, load_addr, load_cmd, load_exp, num_cmds, start, cmd_sent, resp_rdy, resp,
      output cmd, send_cmd, clr_rx_rdy, busy, done, pass_cnt, fail_cnt, first_fail
   );

endinterface

// File: rtl/cmd_script_mem.sv
// Script storage: synchronous write, combinational read, no reset.
module cmd_script_mem #(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned WIDTH = 24
) (
   input  logic                     clk_i,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [WIDTH-1:0]         wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [WIDTH-1:0]         rdata_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/cmd_script_runner.sv
// Runs a stored command script against RemoteComm and tallies pass/fail per entry.
// Optional CMD_SCRIPT_RETRY_EN: a timed-out entry is reissued once before it counts as a fail.
module cmd_script_runner
   import tb_package::*;
#(
   parameter int unsigned DEPTH        = 16,
   parameter int unsigned CMD_W        = 16,
   parameter int unsigned TIMEOUT_CLKS = 10_000_000
) (
   input logic               clk,
   input logic               rst,
   cmd_script_runner_if.slave bus
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;

   state_e           st_q, st_d;
   logic [AW-1:0]    idx_q, idx_d, ff_q, ff_d;
   logic [AW:0]      count_q, count_d, pass_q, pass_d, fail_q, fail_d;
   logic [TW-1:0]    tmo_q, tmo_d;
   logic [7:0]       resp_q, resp_d;
   logic [CMD_W-1:0] cmd_q, cmd_d;
   logic [CMD_W+7:0] rd_word;
   logic [CMD_W-1:0] rd_cmd;
   logic [7:0]       rd_exp;
   logic             timeout, retry, last, pass_ev, fail_ev, advance;

   // Memory is frozen while busy, so idx_q addresses a stable entry for the whole run.
   cmd_script_mem #(
      .DEPTH (DEPTH),
      .WIDTH (CMD_W + 8)
   ) u_mem (
      .clk_i   (clk),
      .we_i    (bus.load_we && (st_q == StIdle)),
      .waddr_i (bus.load_addr),
      .wdata_i ({bus.load_cmd, bus.load_exp}),
      .raddr_i (idx_q),
      .rdata_o (rd_word)
   );

   assign rd_cmd = rd_word[CMD_W+7:8];
   assign rd_exp = rd_word[7:0];

   assign timeout = ((st_q == StWaitSent) || ((st_q == StWaitResp) && !bus.resp_rdy)) &&
                    (tmo_q == TW'(TIMEOUT_CLKS - 1));
   assign last    = ({1'b0, idx_q} == (count_q - 1'b1));
   assign pass_ev = (st_q == StCheck) && (resp_q == rd_exp);
   assign fail_ev = ((st_q == StCheck) && (resp_q != rd_exp)) || (timeout && !retry);
   assign advance = (st_q == StCheck) || (timeout && !retry);

`ifdef CMD_SCRIPT_RETRY_EN
   logic retried_q, retried_d;

   assign retry = timeout && !retried_q;

   always_comb begin
      retried_d = retried_q;
      if (retry) begin
         retried_d = 1'b1;
      end else if (advance) begin
         retried_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) retried_q <= 1'b0;
      else     retried_q <= retried_d;
   end
`else
   assign retry = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) st_q <= StIdle;
      else     st_q <= st_d;
   end

   always_comb begin
      st_d = st_q;
      unique case (st_q)
         StIdle:     if (bus.start) st_d = (bus.num_cmds == '0) ? StDone : StIssue;
         StIssue:    st_d = StWaitSent;
         StWaitSent: begin
            if (timeout)           st_d = (retry || !last) ? StIssue : StDone;
            else if (bus.cmd_sent) st_d = StWaitResp;
         end
         StWaitResp: begin
            if (bus.resp_rdy)  st_d = StCheck;
            else if (timeout)  st_d = (retry || !last) ? StIssue : StDone;
         end
         StCheck:    st_d = last ? StDone : StIssue;
         StDone:     st_d = StIdle;
         default:    st_d = StIdle;
      endcase
   end

   always_comb begin
      bus.send_cmd   = (st_q == StIssue);
      bus.clr_rx_rdy = (st_q == StCheck);
      bus.done       = (st_q == StDone);
      bus.busy       = (st_q != StIdle);
      bus.cmd        = (st_q == StIssue) ? rd_cmd : cmd_q;
   end

   assign bus.pass_cnt   = pass_q;
   assign bus.fail_cnt   = fail_q;
   assign bus.first_fail = ff_q;

   always_comb begin
      idx_d   = idx_q;
      count_d = count_q;
      pass_d  = pass_q;
      fail_d  = fail_q;
      ff_d    = ff_q;
      tmo_d   = tmo_q;
      resp_d  = resp_q;
      cmd_d   = cmd_q;
      case (st_q)
         StIdle: begin
            if (bus.start) begin
               idx_d   = '0;
               count_d = (bus.num_cmds > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : bus.num_cmds;
               pass_d  = '0;
               fail_d  = '0;
               ff_d    = '0;
            end
         end
         StIssue: begin
            tmo_d = '0;
            cmd_d = rd_cmd;
         end
         StWaitSent, StWaitResp: begin
            tmo_d = tmo_q + 1'b1;
            if ((st_q == StWaitResp) && bus.resp_rdy) resp_d = bus.resp;
         end
         default: ;
      endcase
      if (pass_ev) pass_d = pass_q + 1'b1;
      if (fail_ev) begin
         fail_d = fail_q + 1'b1;
         if (fail_q == '0) ff_d = idx_q;
      end
      if (advance && !last) idx_d = idx_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q   <= '0;
         count_q <= '0;
         pass_q  <= '0;
         fail_q  <= '0;
         ff_q    <= '0;
         tmo_q   <= '0;
         resp_q  <= '0;
         cmd_q   <= '0;
      end else begin
         idx_q   <= idx_d;
         count_q <= count_d;
         pass_q  <= pass_d;
         fail_q  <= fail_d;
         ff_q    <= ff_d;
         tmo_q   <= tmo_d;
         resp_q  <= resp_d;
         cmd_q   <= cmd_d;
      end
   end

endmodule
